// File: rtl/spu_pipe_pkg.sv
// Shared widths and payload types for the SPU EX->MEM pipeline register.
package spu_pipe_pkg;

    localparam int DATA_W = 128;
    localparam int PC_W   = 32;
    localparam int REG_W  = 7;

    // Field order is the packing order used for each slot's data vector
    // (regwrite travels separately because a kill must clear it).
    typedef struct packed {
        logic [PC_W-1:0]   jump_pc;
        logic              zero;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rt;
        logic              regwrite;
    } ex_mem_payload_t;

    typedef struct packed {
        logic            valid;
        ex_mem_payload_t payload;
    } ex_mem_slot_t;

endpackage

// File: rtl/spu_pipe_slot.sv
// One pipeline slot: valid + regwrite control bits and a data vector.
// Kill clears only the control bits; the data vector keeps its value.
module spu_pipe_slot #(
    parameter int DAT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             kill,
    input  logic             d_valid,
    input  logic             d_regwrite,
    input  logic [DAT_W-1:0] d_data,
    output logic             q_valid,
    output logic             q_regwrite,
    output logic [DAT_W-1:0] q_data
);

    logic             valid_d, valid_q;
    logic             regwrite_d, regwrite_q;
    logic [DAT_W-1:0] data_d, data_q;

    // Next state: kill beats hold, hold beats load.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        data_d     = data_q;
        if (kill) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (!hold) begin
            valid_d    = d_valid;
            regwrite_d = d_regwrite & d_valid;
            data_d     = d_data;
        end
    end

    // Slot register with synchronous clear of every field.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            data_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            data_q     <= data_d;
        end
    end

    assign q_valid    = valid_q;
    assign q_regwrite = regwrite_q;
    assign q_data     = data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register, DEPTH slots deep, with stall, flush,
// occupancy count and per-slot hazard taps for forwarding/interlock.
module ex_mem_pipe
    import spu_pipe_pkg::*;
#(
    parameter int DATA_W = spu_pipe_pkg::DATA_W,
    parameter int PC_W   = spu_pipe_pkg::PC_W,
    parameter int REG_W  = spu_pipe_pkg::REG_W,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_jump_pc,
    input  logic                       in_zero,
    input  logic [DATA_W-1:0]          in_alu_result,
    input  logic [DATA_W-1:0]          in_store_data,
    input  logic [REG_W-1:0]           in_rt,
    input  logic                       in_regwrite,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_jump_pc,
    output logic                       out_zero,
    output logic [DATA_W-1:0]          out_alu_result,
    output logic [DATA_W-1:0]          out_store_data,
    output logic [REG_W-1:0]           out_rt,
    output logic                       out_regwrite,
    output logic [DEPTH-1:0]           tap_valid,
    output logic [DEPTH-1:0]           tap_regwrite,
    output logic [DEPTH*REG_W-1:0]     tap_rt,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       busy
);

    localparam int DAT_W = PC_W + 1 + 2 * DATA_W + REG_W;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            slot_valid;
    logic [DEPTH-1:0]            slot_rw;
    logic [DEPTH-1:0][DAT_W-1:0] slot_data;
    logic [DAT_W-1:0]            in_data;
    logic [OCC_W-1:0]            occ_d, occ_q;

    // rt sits in the low bits so the hazard taps can slice it directly.
    assign in_data = {in_jump_pc, in_zero, in_alu_result, in_store_data, in_rt};

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic             src_valid;
        logic             src_rw;
        logic [DAT_W-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_rw    = in_regwrite;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = slot_valid[k-1];
            assign src_rw    = slot_rw[k-1];
            assign src_data  = slot_data[k-1];
        end

        spu_pipe_slot #(.DAT_W(DAT_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .hold       (stall),
            .kill       (flush),
            .d_valid    (src_valid),
            .d_regwrite (src_rw),
            .d_data     (src_data),
            .q_valid    (slot_valid[k]),
            .q_regwrite (slot_rw[k]),
            .q_data     (slot_data[k])
        );

        assign tap_rt[k*REG_W +: REG_W] = slot_data[k][REG_W-1:0];
    end

    assign tap_valid    = slot_valid;
    assign tap_regwrite = slot_rw;

    assign out_valid    = slot_valid[DEPTH-1];
    assign out_regwrite = slot_rw[DEPTH-1];
    assign {out_jump_pc, out_zero, out_alu_result, out_store_data, out_rt} = slot_data[DEPTH-1];

    // Occupancy tracks the valid bits: one in at slot0, one out past the last slot.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (!stall) begin
            occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(slot_valid[DEPTH-1]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

    a_occ_matches_valid: assert property (@(posedge clk) disable iff (reset)
        int'(occupancy) == $countones(tap_valid));

endmodule
